// File: rtl/spfs_rsp.sv
// spfs_rsp: SPI flash responder serving READ (0x03), JEDEC ID (0x9F) and status (0x05) from a byte-fetch port
module spfs_rsp #(
  parameter logic [23:0] JEDEC_ID  = 24'hEF4016,
  parameter logic [7:0]  FILL_BYTE = 8'hFF
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        spfs_clk_i,
  input  logic        spfs_cs_i,
  input  logic        spfs_mosi_i,
  output logic        spfs_miso_o,
  output logic        spfs_miso_oe_o,
  output logic        mem_req_o,
  output logic [23:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [7:0]  mem_rdata_i,
  output logic        busy_o,
  output logic        underrun_o,
  input  logic        underrun_clr_i
);
  typedef enum logic [2:0] {IDLE, CMD, ADDR, READ, ID, STAT, IGNORE} state_e;

  state_e      state_q, state_d;
  logic [2:0]  sclk_q, cs_q;
  logic [1:0]  mosi_q;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  rx_q, rx_d, tx_q, tx_d, buf_q, buf_d;
  logic [1:0]  addr_cnt_q, addr_cnt_d, id_idx_q, id_idx_d;
  logic [15:0] addr_sh_q, addr_sh_d;
  logic [23:0] mem_addr_q, mem_addr_d, load_addr_q, load_addr_d;
  logic        miso_q, miso_d, buf_full_q, buf_full_d, need_q, need_d;
  logic        req_q, req_d, stale_q, stale_d, load_pend_q, load_pend_d;
  logic        underrun_q, underrun_d;
  logic        sclk_rise, sclk_fall, cs_rise, cs_fall, cs_low, rise_ev, fall_ev;
  logic        load_ev, byte_done, addr_done, ack, consume, under_ev;
  logic [7:0]  rx_byte, id_byte, load_byte;

  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign cs_rise   = cs_q[1] & ~cs_q[2];
  assign cs_fall   = ~cs_q[1] & cs_q[2];
  assign cs_low    = ~cs_q[1];
  assign rise_ev   = sclk_rise & cs_low & (state_q inside {CMD, ADDR, READ, ID, STAT});
  assign fall_ev   = sclk_fall & cs_low & (state_q inside {READ, ID, STAT});
  assign load_ev   = fall_ev & (bit_cnt_q == 3'd0);
  assign byte_done = rise_ev & (bit_cnt_q == 3'd7);
  assign rx_byte   = {rx_q[6:0], mosi_q[1]};
  assign addr_done = (state_q == ADDR) & byte_done & (addr_cnt_q == 2'd2);
  assign ack       = req_q & mem_ack_i;
  assign consume   = load_ev & (state_q == READ) & buf_full_q;
  assign under_ev  = load_ev & (state_q == READ) & ~buf_full_q;
  assign id_byte   = id_idx_q == 2'd0 ? JEDEC_ID[23:16] : id_idx_q == 2'd1 ? JEDEC_ID[15:8] :
                     id_idx_q == 2'd2 ? JEDEC_ID[7:0] : FILL_BYTE;
  assign load_byte = state_q == READ ? (buf_full_q ? buf_q : FILL_BYTE) : state_q == ID ? id_byte : 8'h00;

  assign spfs_miso_o    = miso_q;
  assign spfs_miso_oe_o = state_q inside {READ, ID, STAT};
  assign mem_req_o      = req_q;
  assign mem_addr_o     = mem_addr_q;
  assign busy_o         = state_q != IDLE;
  assign underrun_o     = underrun_q;

  // two-flop synchronizers plus a history flop for edge detection
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sclk_q <= 3'b000;
      cs_q   <= 3'b111;
      mosi_q <= 2'b00;
    end else begin
      sclk_q <= {sclk_q[1:0], spfs_clk_i};
      cs_q   <= {cs_q[1:0], spfs_cs_i};
      mosi_q <= {mosi_q[0], spfs_mosi_i};
    end
  end

  // next protocol state; a CS rise overrides everything
  always_comb begin
    state_d = state_q;
    if (cs_rise) state_d = IDLE;
    else if (state_q == IDLE && cs_fall) state_d = CMD;
    else if (state_q == CMD && byte_done)
      state_d = rx_byte == 8'h03 ? ADDR : rx_byte == 8'h9F ? ID : rx_byte == 8'h05 ? STAT : IGNORE;
    else if (addr_done) state_d = READ;
  end

  // shift paths, prefetch buffer and fetch handshake
  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    rx_d        = rx_q;
    addr_cnt_d  = addr_cnt_q;
    addr_sh_d   = addr_sh_q;
    tx_d        = tx_q;
    miso_d      = miso_q;
    id_idx_d    = id_idx_q;
    buf_d       = buf_q;
    buf_full_d  = buf_full_q;
    need_d      = need_q;
    req_d       = req_q;
    stale_d     = stale_q;
    mem_addr_d  = mem_addr_q;
    load_addr_d = load_addr_q;
    load_pend_d = load_pend_q;
    underrun_d  = under_ev | (underrun_q & ~underrun_clr_i);
    if (rise_ev) begin
      bit_cnt_d = bit_cnt_q + 3'd1;
      rx_d      = rx_byte;
    end
    if (state_q == ADDR && byte_done) begin
      addr_cnt_d = addr_cnt_q + 2'd1;
      addr_sh_d  = {addr_sh_q[7:0], rx_byte};
    end
    if (fall_ev) begin
      miso_d = load_ev ? load_byte[7] : tx_q[7];
      tx_d   = load_ev ? {load_byte[6:0], 1'b0} : {tx_q[6:0], 1'b0};
    end
    if (load_ev && state_q == ID && id_idx_q != 2'd3) id_idx_d = id_idx_q + 2'd1;
    if (ack) begin
      req_d       = 1'b0;
      stale_d     = 1'b0;
      load_pend_d = 1'b0;
      mem_addr_d  = load_pend_q ? load_addr_q : mem_addr_q + 24'd1;
      if (!stale_q) begin
        buf_d      = mem_rdata_i;
        buf_full_d = 1'b1;
      end
    end
    if (addr_done) begin
      need_d = 1'b1;
      if (req_q && !ack) begin
        load_addr_d = {addr_sh_q, rx_byte};
        load_pend_d = 1'b1;
      end else mem_addr_d = {addr_sh_q, rx_byte};
    end
    if (consume) begin
      buf_full_d = 1'b0;
      need_d     = 1'b1;
    end
    if (cs_rise) begin
      bit_cnt_d  = 3'd0;
      rx_d       = 8'h00;
      addr_cnt_d = 2'd0;
      id_idx_d   = 2'd0;
      miso_d     = 1'b0;
      buf_full_d = 1'b0;
      need_d     = 1'b0;
      if (req_q && !ack) stale_d = 1'b1;
    end
    if (!req_q && need_d) begin
      req_d  = 1'b1;
      need_d = 1'b0;
    end
  end

  // state and datapath registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd0;
      rx_q        <= 8'h00;
      addr_cnt_q  <= 2'd0;
      addr_sh_q   <= 16'h0000;
      tx_q        <= 8'h00;
      miso_q      <= 1'b0;
      id_idx_q    <= 2'd0;
      buf_q       <= 8'h00;
      buf_full_q  <= 1'b0;
      need_q      <= 1'b0;
      req_q       <= 1'b0;
      stale_q     <= 1'b0;
      mem_addr_q  <= 24'h000000;
      load_addr_q <= 24'h000000;
      load_pend_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      addr_cnt_q  <= addr_cnt_d;
      addr_sh_q   <= addr_sh_d;
      tx_q        <= tx_d;
      miso_q      <= miso_d;
      id_idx_q    <= id_idx_d;
      buf_q       <= buf_d;
      buf_full_q  <= buf_full_d;
      need_q      <= need_d;
      req_q       <= req_d;
      stale_q     <= stale_d;
      mem_addr_q  <= mem_addr_d;
      load_addr_q <= load_addr_d;
      load_pend_q <= load_pend_d;
      underrun_q  <= underrun_d;
    end
  end
endmodule
